// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and defaults for the i2c arbiter
// Purpose : arbiter FSM state type and default per-phase timeout.
// Ports   : none (package).
package i2c_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      HOLD   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int TIMEOUT_CYC_DEFAULT = 200000;

endpackage

// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - arbiter to i2c_master command/status bundle
// Purpose : groups the single-byte transaction request toward the shared
//           i2c_master and the status coming back from it.
// Ports   : m_enable, m_slv_addr, m_rnw, m_data_wr (arbiter -> master)
//           m_busy, m_rd_data, m_nack             (master -> arbiter)
// Modports: master (arbiter side), slave (i2c_master side).
interface i2c_arbiter_if;

   logic       m_enable;
   logic [6:0] m_slv_addr;
   logic       m_rnw;
   logic [7:0] m_data_wr;
   logic       m_busy;
   logic [7:0] m_rd_data;
   logic       m_nack;

   modport master (
      output m_enable, m_slv_addr, m_rnw, m_data_wr,
      input  m_busy, m_rd_data, m_nack
   );

   modport slave (
      input  m_enable, m_slv_addr, m_rnw, m_data_wr,
      output m_busy, m_rd_data, m_nack
   );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Purpose : selects the first asserted request at or after ptr, wrapping.
// Ports   : req   in  N   request vector
//           ptr   in  IW  index searched first
//           gnt   out N   one-hot grant (zero when no request)
//           idx   out IW  index of the granted request
//           valid out 1   at least one request present
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      int c;
      c     = 0;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!valid && req[c]) begin
            valid  = 1'b1;
            idx    = IW'(c);
            gnt[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin sharing of one i2c_master among N_REQ requesters
// Purpose : grants one requester at a time, launches a single-byte transfer
//           on the i2c_master, waits for busy to rise and fall, then pulses
//           done with the captured response. Each phase is bounded by
//           TIMEOUT_CYC cycles.
// Ports   : clk, rst_n                       clock, sync active-low reset
//           req/req_addr/req_rnw/req_wdata   per-requester transfer request
//           gnt, done                        one-hot grant, completion pulse
//           rsp_rdata/rsp_nack/rsp_timeout   response, valid with done
//           m                                i2c_master command/status bundle
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*7-1:0] req_addr,
   input  logic [N_REQ-1:0]   req_rnw,
   input  logic [N_REQ*8-1:0] req_wdata,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [7:0]         rsp_rdata,
   output logic               rsp_nack,
   output logic               rsp_timeout,
   i2c_arbiter_if.master      m
);

   localparam int IDXW = $clog2(N_REQ);
   localparam int CNTW = $clog2(TIMEOUT_CYC + 1);

   state_t           state_q, state_d;
   logic [IDXW-1:0]  ptr_q;
   logic [CNTW-1:0]  cnt_q;
   logic             busy_prev_q;
   logic [N_REQ-1:0] arb_gnt;
   logic [IDXW-1:0]  arb_idx;
   logic             arb_valid;
   logic             busy_rise, busy_fall, expired;

   rr_arbiter #(.N(N_REQ), .IW(IDXW)) u_rr (
      .req   (req),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign busy_rise = m.m_busy & ~busy_prev_q;
   assign busy_fall = ~m.m_busy & busy_prev_q;
   // Counter is zero on the first cycle of a phase, so the last allowed
   // cycle is TIMEOUT_CYC-1 and DONE is entered TIMEOUT_CYC cycles in.
   assign expired   = (cnt_q == CNTW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_valid) state_d = LAUNCH;
         LAUNCH:  if (busy_rise) state_d = HOLD;
                  else if (expired) state_d = DONE;
         HOLD:    if (busy_fall || expired) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt          <= '0;
         done         <= '0;
         rsp_rdata    <= '0;
         rsp_nack     <= 1'b0;
         rsp_timeout  <= 1'b0;
         m.m_enable   <= 1'b0;
         m.m_slv_addr <= '0;
         m.m_rnw      <= 1'b0;
         m.m_data_wr  <= '0;
         ptr_q        <= '0;
         cnt_q        <= '0;
         busy_prev_q  <= 1'b0;
      end else begin
         busy_prev_q <= m.m_busy;
         done        <= '0;
         case (state_q)
            IDLE: begin
               // Winner's request is latched here; later requester changes
               // have no effect until the next grant.
               if (arb_valid) begin
                  gnt          <= arb_gnt;
                  ptr_q        <= (arb_idx == IDXW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                  m.m_slv_addr <= req_addr[int'(arb_idx)*7 +: 7];
                  m.m_rnw      <= req_rnw[arb_idx];
                  m.m_data_wr  <= req_wdata[int'(arb_idx)*8 +: 8];
                  m.m_enable   <= 1'b1;
                  cnt_q        <= '0;
               end
            end
            LAUNCH: begin
               if (busy_rise) begin
                  m.m_enable <= 1'b0;
                  cnt_q      <= '0;
               end else if (expired) begin
                  done        <= gnt;
                  rsp_timeout <= 1'b1;
                  rsp_nack    <= 1'b1;
                  m.m_enable  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (busy_fall) begin
                  done        <= gnt;
                  rsp_nack    <= m.m_nack;
                  rsp_timeout <= 1'b0;
                  if (m.m_rnw) rsp_rdata <= m.m_rd_data;
               end else if (expired) begin
                  done        <= gnt;
                  rsp_timeout <= 1'b1;
                  rsp_nack    <= 1'b1;
                  m.m_enable  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE:    gnt <= '0;
            default: gnt <= '0;
         endcase
      end
   end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing one i2c_master (2..8).
REQ-002 Parameter TIMEOUT_CYC, 200000, clk cycles allowed per transfer phase before abort.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  N_REQ  per-requester transfer request, level, held until own done.
REQ-006 req_addr  input  N_REQ*7  per-requester 7-bit slave address, slot i at [7i+6:7i].
REQ-007 req_rnw  input  N_REQ  per-requester direction, 1=read, 0=write.
REQ-008 req_wdata  input  N_REQ*8  per-requester write byte, slot i at [8i+7:8i].
REQ-009 gnt  output  N_REQ  one-hot grant, high from grant until done.
REQ-010 done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-011 rsp_rdata  output  8  read byte; valid with done, held until next done.
REQ-012 rsp_nack  output  1  slave NACK flag; valid with done.
REQ-013 rsp_timeout  output  1  transfer aborted by timeout; valid with done.
REQ-014 m_enable  output  1  to i2c_master enable.
REQ-015 m_slv_addr  output  7  to i2c_master slv_addr.
REQ-016 m_rnw  output  1  to i2c_master RnW.
REQ-017 m_data_wr  output  8  to i2c_master data_wr.
REQ-018 m_busy  input  1  from i2c_master busy.
REQ-019 m_rd_data  input  8  from i2c_master rd_data.
REQ-020 m_nack  input  1  from i2c_master nAck.

Function
REQ-021 FSM states IDLE, LAUNCH, HOLD, DONE; one single-byte I2C transaction per grant.
REQ-022 IDLE: any req bit high -> round-robin pick, starting at (last granted index + 1) mod N_REQ; set gnt, latch addr/rnw/wdata of winner into m_* registers; -> LAUNCH next cycle.
REQ-023 LAUNCH: m_enable=1; on m_busy rising edge (registered m_busy_prev=0, m_busy=1) -> HOLD with m_enable=0 in the same edge.
REQ-024 HOLD: m_enable=0; on m_busy falling edge -> DONE, capturing m_rd_data into rsp_rdata and m_nack into rsp_nack.
REQ-025 DONE: done[granted]=1 for exactly one cycle, gnt cleared same cycle end, -> IDLE; no new grant in the DONE cycle.
REQ-026 m_slv_addr/m_rnw/m_data_wr stay constant from LAUNCH entry through DONE; requester input changes after grant are ignored.
REQ-027 req deasserted by granted requester mid-transfer: transfer completes, done still pulses.
REQ-028 Timeout counter clears on LAUNCH and HOLD entry, increments each cycle in those states; reaching TIMEOUT_CYC -> DONE with rsp_timeout=1, rsp_nack=1, rsp_rdata unchanged, m_enable=0.
REQ-029 rsp_timeout=0 on every non-timeout completion.
REQ-030 Minimum gap between two grants: 2 cycles (DONE, IDLE).
REQ-031 Simultaneous requests: exactly one grant; all continuously-requesting requesters served within N_REQ transactions.
REQ-032 Write transfers: rsp_rdata retains previous value.

Reset
REQ-033 rst_n low at rising clk: state=IDLE, gnt=0, done=0, m_enable=0, m_slv_addr=0, m_rnw=0, m_data_wr=0, rsp_rdata=0, rsp_nack=0, rsp_timeout=0, round-robin pointer selects index 0 first, timeout counter=0.
REQ-034 Reset mid-transfer drops gnt and m_enable immediately; no done pulse for the aborted transfer.

Structure
REQ-035 Shared package i2c_pkg holds the state_t enum and TIMEOUT_CYC default.
REQ-036 Sub-module rr_arbiter (req vector, pointer in; one-hot grant, index out) is instantiated once.

Verification (bench pairs with i2c_master and a slave model)
REQ-037 req=0001, addr0=0x50, rnw=0, wdata=0xA5 -> bus byte 0xA0 then 0xA5, done[0] once, rsp_nack=0, rsp_timeout=0.
REQ-038 req=0100, addr2=0x48, rnw=1, slave returns 0x3C -> rsp_rdata=0x3C with done[2], gnt=0100 throughout.
REQ-039 req=1111 held continuously -> grant order 0,1,2,3,0; exactly one gnt bit high at any time.
REQ-040 Write to absent address 0x22 -> done pulses, rsp_nack=1, rsp_timeout=0.
REQ-041 m_busy forced 0, TIMEOUT_CYC=16 -> done at LAUNCH entry +16 cycles, rsp_timeout=1, m_enable=0.
REQ-042 rst_n low during HOLD -> next cycle gnt=0, m_enable=0, no done; fresh req=0010 afterwards served normally.
